// File: rtl/id_forward_scoreboard.sv
// ID-stage hazard/forwarding unit: shift scoreboard of in-flight writes, youngest-match operand forwarding.
// Latency: stall, fwd_sel_* and *_data are combinational (0 cycles); the scoreboard advances one stage per clock.
// Backpressure: stall holds PC/IF_ID and bubbles ID_EX only while a youngest matching producer is not ready.
// Optional stall-cycle counter (stall_cnt port) is built when ID_SB_PERF_CNT_EN is defined.
module id_forward_scoreboard #(
   parameter int AW       = 5,
   parameter int DW       = 32,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1,
   localparam int SW      = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue_valid,
   input  logic                issue_wen,
   input  logic                issue_load,
   input  logic [AW-1:0]       issue_waddr,
   input  logic                need_rs,
   input  logic                need_rt,
   input  logic [AW-1:0]       rs_addr,
   input  logic [AW-1:0]       rt_addr,
   input  logic [DW-1:0]       rf_rs_data,
   input  logic [DW-1:0]       rf_rt_data,
   input  logic [DEPTH*DW-1:0] stage_data,
   input  logic                flush,
   output logic                stall,
   output logic [SW-1:0]       fwd_sel_rs,
   output logic [SW-1:0]       fwd_sel_rt,
   output logic [DW-1:0]       rs_data,
   output logic [DW-1:0]       rt_data
`ifdef ID_SB_PERF_CNT_EN
   ,
   output logic [31:0]         stall_cnt
`endif
);

   localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic          v;
      logic [AW-1:0] waddr;
      logic [RW-1:0] rdy_at;
   } entry_t;

   typedef struct packed {
      logic          pend;
      logic [SW-1:0] sel;
      logic [DW-1:0] data;
   } res_t;

   entry_t [DEPTH-1:0] sb;
   entry_t             new_e;
   res_t               res_rs;
   res_t               res_rt;

   // Scanning oldest to youngest lets the youngest match overwrite older ones.
   function automatic res_t lookup(
      input logic               need,
      input logic [AW-1:0]      addr,
      input logic [DW-1:0]      rf,
      input entry_t [DEPTH-1:0] e,
      input logic [DEPTH*DW-1:0] sd
   );
      res_t r;
      r.pend = 1'b0;
      r.sel  = '0;
      r.data = rf;
      if (need && (addr != '0)) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (e[k].v && (e[k].waddr == addr)) begin
               if (RW'(k) >= e[k].rdy_at) begin
                  r.pend = 1'b0;
                  r.sel  = SW'(k + 1);
                  r.data = sd[k*DW +: DW];
               end else begin
                  r.pend = 1'b1;
                  r.sel  = '0;
                  r.data = rf;
               end
            end
         end
      end
      return r;
   endfunction

   assign res_rs = lookup(need_rs, rs_addr, rf_rs_data, sb, stage_data);
   assign res_rt = lookup(need_rt, rt_addr, rf_rt_data, sb, stage_data);

   assign stall      = issue_valid & (res_rs.pend | res_rt.pend);
   assign fwd_sel_rs = res_rs.sel;
   assign fwd_sel_rt = res_rt.sel;
   assign rs_data    = res_rs.data;
   assign rt_data    = res_rt.data;

   // A stalled instruction stays in ID, so only its eventual issue enters the scoreboard.
   assign new_e.v      = issue_valid & issue_wen & ~stall & (issue_waddr != '0);
   assign new_e.waddr  = issue_waddr;
   assign new_e.rdy_at = issue_load ? RW'(LOAD_LAT) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb <= '0;
      end else if (flush) begin
         sb <= '0;
      end else begin
         sb[0] <= new_e;
         for (int k = 1; k < DEPTH; k++) begin
            sb[k] <= sb[k-1];
         end
      end
   end

`ifdef ID_SB_PERF_CNT_EN
   // Free-running; flush does not clear it and it wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
